// File: rtl/led_blinker_pkg.sv
// Shared encodings and helpers for the multi-channel LED blinker.
// Mode values match the cfg_mode field written by the register block.
package led_blinker_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SOLID  = 3'd1,
    ST_ON_PH  = 3'd2,
    ST_OFF_PH = 3'd3,
    ST_DONE   = 3'd4
  } chan_state_e;

  // A programmed length of zero behaves as a length of one.
  function automatic int unsigned eff_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/led_blinker_chan.sv
// One LED channel: config registers, phase/burst counters and pattern FSM.
// led and done are registered and derived from the next state.
module led_blinker_chan
  import led_blinker_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned BURST_W = 4
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               tick,
  input  logic               we,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_on,
  input  logic [CNT_W-1:0]   cfg_off,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic               led,
  output logic               done
);

  chan_state_e        state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   on_q, on_d;
  logic [CNT_W-1:0]   off_q, off_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               led_q, led_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   on_last;
  logic [CNT_W-1:0]   off_last;

  always_comb begin
    on_last  = CNT_W'(eff_len(32'(on_q)) - 1);
    off_last = CNT_W'(eff_len(32'(off_q)) - 1);

    state_d = state_q;
    mode_d  = mode_q;
    on_d    = on_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;

    // A write overrides any phase end that coincides with it.
    if (we) begin
      mode_d = mode_e'(cfg_mode);
      on_d   = cfg_on;
      off_d  = cfg_off;
      cnt_d  = '0;
      rem_d  = BURST_W'(eff_len(32'(cfg_burst)));
      case (mode_e'(cfg_mode))
        MODE_OFF:   state_d = ST_IDLE;
        MODE_SOLID: state_d = ST_SOLID;
        default:    state_d = ST_ON_PH;
      endcase
    end else if (tick) begin
      case (state_q)
        ST_ON_PH: begin
          if (cnt_q == on_last) begin
            state_d = ST_OFF_PH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_OFF_PH: begin
          if (cnt_q == off_last) begin
            cnt_d = '0;
            if (mode_q == MODE_BURST) begin
              rem_d   = rem_q - BURST_W'(1);
              state_d = (rem_q == BURST_W'(1)) ? ST_DONE : ST_ON_PH;
            end else begin
              state_d = ST_ON_PH;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    led_d  = (state_d == ST_SOLID) || (state_d == ST_ON_PH);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_OFF;
      on_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      on_q    <= on_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign led  = led_q;
  assign done = done_q;

endmodule

// File: rtl/led_blinker_multi.sv
// Multi-channel LED pattern generator: shared prescaler, write decode and
// N_CH independent channel FSMs.
module led_blinker_multi
  import led_blinker_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned BURST_W  = 4,
  parameter int unsigned PRESCALE = 1,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               enable,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_on,
  input  logic [CNT_W-1:0]   cfg_off,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic [N_CH-1:0]    led_out,
  output logic [N_CH-1:0]    done
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic [N_CH-1:0]  we_ch;

  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (enable) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // Channel indices at or beyond N_CH match no strobe, so such writes drop.
  always_comb begin
    we_ch = '0;
    if (cfg_we) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (cfg_ch == CH_W'(i)) begin
          we_ch[i] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    led_blinker_chan #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
    ) u_chan (
      .clk       (clk),
      .clear     (clear),
      .tick      (tick),
      .we        (we_ch[g]),
      .cfg_mode  (cfg_mode),
      .cfg_on    (cfg_on),
      .cfg_off   (cfg_off),
      .cfg_burst (cfg_burst),
      .led       (led_out[g]),
      .done      (done[g])
    );
  end

endmodule

// File: tb/tb_led_blinker_multi.sv
// Directed bench for led_blinker_multi with a PRESCALE=1 and a PRESCALE=4 instance.
module tb_led_blinker_multi;

  localparam int unsigned N = 3;

  logic         clk = 1'b0;
  logic         clear;
  logic         enable;
  logic         cfg_we;
  logic [1:0]   cfg_ch;
  logic [1:0]   cfg_mode;
  logic [7:0]   cfg_on;
  logic [7:0]   cfg_off;
  logic [3:0]   cfg_burst;
  logic [N-1:0] led1, done1, led4, done4;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  led_blinker_multi #(
    .N_CH(N), .CNT_W(8), .BURST_W(4), .PRESCALE(1)
  ) dut (
    .clk(clk), .clear(clear), .enable(enable), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_on(cfg_on),
    .cfg_off(cfg_off), .cfg_burst(cfg_burst),
    .led_out(led1), .done(done1)
  );

  led_blinker_multi #(
    .N_CH(N), .CNT_W(8), .BURST_W(4), .PRESCALE(4)
  ) dut_p4 (
    .clk(clk), .clear(clear), .enable(enable), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_on(cfg_on),
    .cfg_off(cfg_off), .cfg_burst(cfg_burst),
    .led_out(led4), .done(done4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [1:0] mode,
                          input logic [7:0] on, input logic [7:0] off,
                          input logic [3:0] b);
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_on    = on;
    cfg_off   = off;
    cfg_burst = b;
    cfg_we    = 1'b1;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; enable = 1'b1; cfg_we = 1'b0;
    cfg_ch = '0; cfg_mode = '0; cfg_on = '0; cfg_off = '0; cfg_burst = '0;
    step();
    step();
    compared++;
    if ({led1, done1, led4, done4} !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got %b expected 0", {led1, done1, led4, done4});
    end
    clear = 1'b0;
    for (int i = 0; i < 50; i++) begin
      compared++;
      if ({led1, done1} !== 6'b0) begin
        mismatched++;
        $display("FAIL idle_after_reset cyc%0d: got %b expected 000000", i, {led1, done1});
      end
      step();
    end
  endtask

  task automatic test_blink();
    logic [2:0] exp;
    do_write(2'd0, 2'd2, 8'd3, 8'd2, 4'd0);
    for (int i = 0; i < 20; i++) begin
      exp = {2'b00, ((i % 5) < 3) ? 1'b1 : 1'b0};
      compared++;
      if (led1 !== exp) begin
        mismatched++;
        $display("FAIL blink_3_2 cyc%0d: got %b expected %b", i, led1, exp);
      end
      step();
    end
  endtask

  task automatic test_burst();
    logic pat [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_write(2'd1, 2'd3, 8'd2, 8'd1, 4'd3);
    for (int i = 0; i < 15; i++) begin
      logic [1:0] exp;
      exp = (i < 9) ? {pat[i], 1'b0} : 2'b01;
      compared++;
      if ({led1[1], done1[1]} !== exp) begin
        mismatched++;
        $display("FAIL burst_led_done cyc%0d: got %b expected %b", i, {led1[1], done1[1]}, exp);
      end
      step();
    end
    do_write(2'd1, 2'd0, 8'd0, 8'd0, 4'd0);
    compared++;
    if ({led1[1], done1[1]} !== 2'b00) begin
      mismatched++;
      $display("FAIL burst_rewrite_off: got %b expected 00", {led1[1], done1[1]});
    end
  endtask

  task automatic test_zero_len_solid_ignore();
    do_write(2'd0, 2'd2, 8'd0, 8'd0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (led1[0] !== ((i % 2) == 0)) begin
        mismatched++;
        $display("FAIL zero_len_toggle cyc%0d: got %b expected %b", i, led1[0], (i % 2) == 0);
      end
      step();
    end
    do_write(2'd0, 2'd1, 8'd0, 8'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (led1 !== 3'b001) begin
        mismatched++;
        $display("FAIL solid cyc%0d: got %b expected 001", i, led1);
      end
      step();
    end
    do_write(2'd3, 2'd1, 8'd5, 8'd5, 4'd1);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if ({led1, done1} !== 6'b001000) begin
        mismatched++;
        $display("FAIL ignored_ch3 cyc%0d: got %b expected 001000", i, {led1, done1});
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    do_write(2'd0, 2'd2, 8'd3, 8'd2, 4'd0);
    step();
    step();
    // Rewrite lands on the edge where the on=3 phase would have ended.
    do_write(2'd0, 2'd2, 8'd1, 8'd4, 4'd0);
    for (int i = 0; i < 10; i++) begin
      compared++;
      if (led1[0] !== ((i % 5) == 0)) begin
        mismatched++;
        $display("FAIL rewrite_1_4 cyc%0d: got %b expected %b", i, led1[0], (i % 5) == 0);
      end
      step();
    end
  endtask

  task automatic test_enable();
    logic [2:0] frz_exp [4] = '{3'b000, 3'b000, 3'b010, 3'b010};
    do_write(2'd0, 2'd2, 8'd3, 8'd2, 4'd0);
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (led1[0] !== ((i % 5) < 3)) begin
        mismatched++;
        $display("FAIL pre_freeze cyc%0d: got %b expected %b", i, led1[0], (i % 5) < 3);
      end
      step();
    end
    enable = 1'b0;
    for (int j = 0; j < 4; j++) begin
      compared++;
      if (led1 !== frz_exp[j]) begin
        mismatched++;
        $display("FAIL frozen cyc%0d: got %b expected %b", j, led1, frz_exp[j]);
      end
      if (j == 1) do_write(2'd1, 2'd1, 8'd1, 8'd1, 4'd1);
      else step();
    end
    enable = 1'b1;
    for (int i = 3; i < 13; i++) begin
      compared++;
      if (led1[0] !== ((i % 5) < 3)) begin
        mismatched++;
        $display("FAIL resume cyc%0d: got %b expected %b", i, led1[0], (i % 5) < 3);
      end
      step();
    end
  endtask

  task automatic test_clear_with_write();
    clear = 1'b1;
    do_write(2'd0, 2'd1, 8'd1, 8'd1, 4'd1);
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if ({led1, done1, led4, done4} !== '0) begin
        mismatched++;
        $display("FAIL clear_beats_write cyc%0d: got %b expected 0", i, {led1, done1, led4, done4});
      end
      step();
    end
  endtask

  task automatic test_prescale();
    logic prev;
    bit   found;
    int   n;
    do_write(2'd0, 2'd2, 8'd2, 8'd1, 4'd0);
    found = 0;
    prev  = led4[0];
    for (int t = 0; t < 40 && !found; t++) begin
      step();
      if (prev === 1'b0 && led4[0] === 1'b1) found = 1;
      prev = led4[0];
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL p4_rise_timeout: got no rising edge expected one within 40 cycles");
    end
    for (int p = 0; p < 2; p++) begin
      n = 0;
      while (led4[0] === 1'b1 && n < 30) begin n++; step(); end
      compared++;
      if (n != 8) begin
        mismatched++;
        $display("FAIL p4_high_len p%0d: got %0d expected 8", p, n);
      end
      n = 0;
      while (led4[0] === 1'b0 && n < 30) begin n++; step(); end
      compared++;
      if (n != 4) begin
        mismatched++;
        $display("FAIL p4_low_len p%0d: got %0d expected 4", p, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_burst();
    test_zero_len_solid_ignore();
    test_back_to_back();
    test_enable();
    test_clear_with_write();
    test_prescale();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
